// File: rtl/regfile_wr_arbiter.sv
// Purpose : shares the register file's single write port between pipeline writeback (req 0) and the multi-cycle unit (req 1).
// Latency : 1 cycle from a valid/ready transfer to the registered regWrite pulse; address/data hold between writes.
// Backpr. : fixed priority to writeback; a requester-1 request denied STARVE_LIMIT cycles in a row is granted next.
//
// Ports:
//   clk, reset            clock (posedge) and asynchronous active-low reset
//   wb_valid/_reg_num/_data, wb_ready   requester 0 (writeback) handshake
//   mc_valid/_reg_num/_data, mc_ready   requester 1 (mul/div/load return) handshake
//   regWrite, write_reg_num, write_data registered register-file write port
//   starve_cnt            consecutive denied cycles of requester 1 (debug)
module regfile_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int DROP_R0      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg_num,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_reg_num,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_reg_num,
    output logic [DATA_W-1:0] write_data,
    output logic [3:0]        starve_cnt
);

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_FORCE_MC = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_reg_num_q, write_reg_num_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;

    logic                wb_rdy;
    logic                mc_rdy;
    logic                wb_xfer;
    logic                mc_xfer;
    logic [3:0]          cnt_inc;
    logic [ADDR_W-1:0]   sel_num;
    logic [DATA_W-1:0]   sel_data;

    always_comb begin
        wb_rdy          = 1'b0;
        mc_rdy          = 1'b0;
        wb_xfer         = 1'b0;
        mc_xfer         = 1'b0;
        cnt_inc         = 4'd0;
        sel_num         = wb_reg_num;
        sel_data        = wb_data;
        state_d         = state_q;
        starve_cnt_d    = starve_cnt_q;
        reg_write_d     = 1'b0;
        write_reg_num_d = write_reg_num_q;
        write_data_d    = write_data_q;

        // Readies are forced low while reset is held so nothing is accepted
        // that could never be written.
        if (reset) begin
            case (state_q)
                ST_NORMAL: begin
                    wb_rdy = wb_valid;
                    mc_rdy = mc_valid & ~wb_valid;
                end
                ST_FORCE_MC: begin
                    wb_rdy = 1'b0;
                    mc_rdy = mc_valid;
                end
                default: begin
                    wb_rdy = 1'b0;
                    mc_rdy = 1'b0;
                end
            endcase
        end

        wb_xfer = wb_valid & wb_rdy;
        mc_xfer = mc_valid & mc_rdy;

        cnt_inc = (starve_cnt_q == 4'd15) ? 4'd15 : starve_cnt_q + 4'd1;

        // Count only consecutive denials; a grant or a withdrawn request restarts it.
        if (!mc_valid || mc_xfer) begin
            starve_cnt_d = 4'd0;
        end else begin
            starve_cnt_d = cnt_inc;
        end

        case (state_q)
            ST_NORMAL: begin
                if (mc_valid && !mc_xfer && cnt_inc == LIMIT_C) begin
                    state_d = ST_FORCE_MC;
                end
            end
            ST_FORCE_MC: begin
                if (mc_xfer || !mc_valid) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        // At most one transfer per cycle, so a simple select is enough.
        if (mc_xfer) begin
            sel_num  = mc_reg_num;
            sel_data = mc_data;
        end

        if (wb_xfer || mc_xfer) begin
            write_reg_num_d = sel_num;
            write_data_d    = sel_data;
            // Register 0 is hardwired: the transfer completes but no write is issued.
            reg_write_d     = !((DROP_R0 != 0) && (sel_num == '0));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_NORMAL;
            starve_cnt_q    <= 4'd0;
            reg_write_q     <= 1'b0;
            write_reg_num_q <= '0;
            write_data_q    <= '0;
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            reg_write_q     <= reg_write_d;
            write_reg_num_q <= write_reg_num_d;
            write_data_q    <= write_data_d;
        end
    end

    assign wb_ready      = wb_rdy;
    assign mc_ready      = mc_rdy;
    assign regWrite      = reg_write_q;
    assign write_reg_num = write_reg_num_q;
    assign write_data    = write_data_q;
    assign starve_cnt    = starve_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LIMIT  = 4;

    logic              clk;
    logic              reset;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_reg_num;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_reg_num;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              regWrite;
    logic [ADDR_W-1:0] write_reg_num;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        starve_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] rf [32];

    regfile_wr_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT), .DROP_R0(1)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg_num(wb_reg_num), .wb_data(wb_data), .wb_ready(wb_ready),
        .mc_valid(mc_valid), .mc_reg_num(mc_reg_num), .mc_data(mc_data), .mc_ready(mc_ready),
        .regWrite(regWrite), .write_reg_num(write_reg_num), .write_data(write_data),
        .starve_cnt(starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the write port, written on the falling edge.
    always @(negedge clk) begin
        if (regWrite) rf[write_reg_num] <= write_data;
    end

    typedef struct {
        logic              wbv;
        logic [ADDR_W-1:0] wbr;
        logic [DATA_W-1:0] wbd;
        logic              mcv;
        logic [ADDR_W-1:0] mcr;
        logic [DATA_W-1:0] mcd;
        logic              e_wb_rdy;
        logic              e_mc_rdy;
        logic              e_rw;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic [3:0]        e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wbv, int wbr, int wbd, logic mcv, int mcr, int mcd,
                                logic ewr, logic emr, logic erw, int ea, int ed, int ec);
        vec_t v;
        v.wbv = wbv; v.wbr = ADDR_W'(wbr); v.wbd = DATA_W'(wbd);
        v.mcv = mcv; v.mcr = ADDR_W'(mcr); v.mcd = DATA_W'(mcd);
        v.e_wb_rdy = ewr; v.e_mc_rdy = emr; v.e_rw = erw;
        v.e_addr = ADDR_W'(ea); v.e_data = DATA_W'(ed); v.e_cnt = 4'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wbv, input logic [ADDR_W-1:0] wbr, input logic [DATA_W-1:0] wbd,
                         input logic mcv, input logic [ADDR_W-1:0] mcr, input logic [DATA_W-1:0] mcd);
        wb_valid = wbv; wb_reg_num = wbr; wb_data = wbd;
        mc_valid = mcv; mc_reg_num = mcr; mc_data = mcd;
    endtask

    // Reference model state for the random phase
    int                denied;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    initial begin
        logic              ewr, emr;
        logic              wbv, mcv;
        logic [ADDR_W-1:0] wbr, mcr;
        logic [DATA_W-1:0] wbd, mcd;

        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset with both requesters asking: nothing may be accepted.
        reset = 1'b0;
        drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66);
        #2;
        chk("rst_wb_ready", 64'(wb_ready), 64'd0);
        chk("rst_mc_ready", 64'(mc_ready), 64'd0);
        chk("rst_regWrite", 64'(regWrite), 64'd0);
        chk("rst_addr", 64'(write_reg_num), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_cnt", 64'(starve_cnt), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed vectors: lone wb, contention, withdrawal, r0 drop, same-register ordering.
        tbl.push_back(mk(1, 2, 10,     0, 0, 0,       1, 0, 1, 2, 10, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0, 0, 2, 10, 0));
        tbl.push_back(mk(1, 1, 'h101,  1, 3, 'h33,    1, 0, 1, 1, 'h101, 1));
        tbl.push_back(mk(1, 1, 'h102,  1, 3, 'h33,    1, 0, 1, 1, 'h102, 2));
        tbl.push_back(mk(1, 1, 'h103,  1, 3, 'h33,    1, 0, 1, 1, 'h103, 3));
        tbl.push_back(mk(1, 1, 'h104,  1, 3, 'h33,    1, 0, 1, 1, 'h104, 4));
        tbl.push_back(mk(1, 1, 'h105,  1, 3, 'h33,    0, 1, 1, 3, 'h33, 0));
        tbl.push_back(mk(1, 1, 'h105,  1, 4, 'h44,    1, 0, 1, 1, 'h105, 1));
        tbl.push_back(mk(1, 1, 'h106,  1, 4, 'h44,    1, 0, 1, 1, 'h106, 2));
        tbl.push_back(mk(1, 1, 'h107,  1, 4, 'h44,    1, 0, 1, 1, 'h107, 3));
        tbl.push_back(mk(1, 1, 'h108,  1, 4, 'h44,    1, 0, 1, 1, 'h108, 4));
        tbl.push_back(mk(1, 1, 'h109,  0, 0, 0,       0, 0, 0, 1, 'h108, 0));
        tbl.push_back(mk(1, 1, 'h109,  0, 0, 0,       1, 0, 1, 1, 'h109, 0));
        tbl.push_back(mk(1, 0, 'hFFFF, 0, 0, 0,       1, 0, 0, 0, 'hFFFF, 0));
        tbl.push_back(mk(1, 17, 7,     0, 0, 0,       1, 0, 1, 17, 7, 0));
        tbl.push_back(mk(0, 0, 0,      1, 17, 9,      0, 1, 1, 17, 9, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0, 0, 17, 9, 0));
        tbl.push_back(mk(0, 0, 0,      1, 0, 5,       0, 1, 0, 0, 5, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].wbv, tbl[i].wbr, tbl[i].wbd, tbl[i].mcv, tbl[i].mcr, tbl[i].mcd);
            #3;
            chk($sformatf("v%0d_wb_ready", i), 64'(wb_ready), 64'(tbl[i].e_wb_rdy));
            chk($sformatf("v%0d_mc_ready", i), 64'(mc_ready), 64'(tbl[i].e_mc_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_regWrite", i), 64'(regWrite), 64'(tbl[i].e_rw));
            chk($sformatf("v%0d_addr", i), 64'(write_reg_num), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_data", i), 64'(write_data), 64'(tbl[i].e_data));
            chk($sformatf("v%0d_cnt", i), 64'(starve_cnt), 64'(tbl[i].e_cnt));
        end
        chk("rf17_last_grant_wins", 64'(rf[17]), 64'd9);

        // Reset arriving between an mc transfer and the edge that would issue it.
        drive(1'b1, 5'd6, 32'hA1, 1'b1, 5'd7, 32'hB2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_cnt", 64'(starve_cnt), 64'd2);
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hB2);
        #3;
        chk("pre_rst_mc_ready", 64'(mc_ready), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_mc_ready", 64'(mc_ready), 64'd0);
        chk("midrst_cnt_async", 64'(starve_cnt), 64'd0);
        @(posedge clk); #1;
        chk("midrst_regWrite", 64'(regWrite), 64'd0);
        chk("midrst_addr", 64'(write_reg_num), 64'd0);
        chk("midrst_data", 64'(write_data), 64'd0);
        chk("midrst_cnt", 64'(starve_cnt), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset = 1'b1;

        // Random phase against a model: requester 1 is forced once it has been
        // denied LIMIT consecutive cycles; otherwise writeback has priority.
        denied = 0;
        m_addr = '0;
        m_data = '0;
        wbv = 1'b0; mcv = 1'b0;
        wbr = '0; mcr = '0; wbd = '0; mcd = '0;
        ewr = 1'b0; emr = 1'b0;
        for (int c = 0; c < 500; c++) begin
            // Pending, un-granted requests hold their payload; mc may withdraw.
            if (!(wbv && !ewr)) begin
                wbv = ($urandom_range(0, 9) < 7);
                wbr = ADDR_W'($urandom_range(0, 31));
                wbd = $urandom;
            end
            if (mcv && !emr) begin
                if ($urandom_range(0, 9) == 0) mcv = 1'b0;
            end else begin
                mcv = ($urandom_range(0, 9) < 6);
                mcr = ADDR_W'($urandom_range(0, 31));
                mcd = $urandom;
            end
            drive(wbv, wbr, wbd, mcv, mcr, mcd);

            if (denied >= LIMIT) begin
                ewr = 1'b0;
                emr = mcv;
            end else begin
                ewr = wbv;
                emr = mcv && !wbv;
            end

            if (mcv && !emr) denied = denied + 1;
            else             denied = 0;

            m_rw = 1'b0;
            if (emr) begin
                m_addr = mcr; m_data = mcd; m_rw = (mcr != 0);
            end else if (ewr) begin
                m_addr = wbr; m_data = wbd; m_rw = (wbr != 0);
            end

            #3;
            chk("rnd_wb_ready", 64'(wb_ready), 64'(ewr));
            chk("rnd_mc_ready", 64'(mc_ready), 64'(emr));
            @(posedge clk); #1;
            chk("rnd_regWrite", 64'(regWrite), 64'(m_rw));
            chk("rnd_addr", 64'(write_reg_num), 64'(m_addr));
            chk("rnd_data", 64'(write_data), 64'(m_data));
            chk("rnd_cnt", 64'(starve_cnt), 64'((denied > 15) ? 15 : denied));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
